// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port dmem syncram between the processor (port 0) and a
//   peripheral master (port 1). The processor has fixed priority. The
//   peripheral uses idle slots and may lock short bursts, which stalls the CPU.
//
//   Optional feature: define STARVE_GUARD_EN to add a port-1 wait counter.
//   After MAX_WAIT lost cycles it forces one port-1 grant.
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   p0_req/addr/wdata/wren processor access; p0_rdata = dmem_q
//   p0_stall               processor holds its memory-stage op this cycle
//   p1_req/lock/addr/wdata/wren  peripheral access; p1_lock keeps the port
//   p1_gnt                 peripheral access performed this cycle
//   p1_rvalid, p1_rdata    peripheral read data (one cycle after a read grant)
//   dmem_addr/data/wren    to dmem; dmem_q from dmem
module dmem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_wren,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_wren,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
);

  localparam int RUN_W = $clog2(LOCK_MAX + 1);

  logic             p1_win, p0_win;
  logic             lock_hold, starved;
  logic [RUN_W-1:0] run_cnt, run_inc;

  // The winner is gated by reset, so the dmem side stays quiet while reset is low.
  assign p1_win   = reset & p1_req & (~p0_req | lock_hold | starved);
  assign p0_win   = reset & p0_req & ~p1_win;
  assign p1_gnt   = p1_win;
  assign p0_stall = p0_req & p1_win;

  assign p0_rdata = dmem_q;
  assign p1_rdata = dmem_q;

  always_comb begin
    dmem_addr = '0;
    dmem_data = '0;
    dmem_wren = 1'b0;
    if (p1_win) begin
      dmem_addr = p1_addr;
      dmem_data = p1_wdata;
      dmem_wren = p1_wren;
    end else if (p0_win) begin
      dmem_addr = p0_addr;
      dmem_data = p0_wdata;
      dmem_wren = p0_wren;
    end
  end

  assign run_inc = run_cnt + RUN_W'(1);

  // The lock survives only while the burst stays below LOCK_MAX grants.
  // On the grant that reaches LOCK_MAX, the counter wraps to 0 and the lock
  // drops. A waiting p0 then wins the next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_hold <= 1'b0;
      run_cnt   <= '0;
      p1_rvalid <= 1'b0;
    end else begin
      p1_rvalid <= p1_win & ~p1_wren;
      if (p1_win && (run_inc < RUN_W'(LOCK_MAX))) begin
        run_cnt   <= run_inc;
        lock_hold <= p1_lock;
      end else begin
        run_cnt   <= '0;
        lock_hold <= 1'b0;
      end
    end
  end

`ifdef STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 wait_cnt <= '0;
    else if (p1_win || !p1_req) wait_cnt <= '0;
    else if (!starved)          wait_cnt <= wait_cnt + WAIT_W'(1);
  end
`else
  logic [31:0] unused_max_wait;

  assign unused_max_wait = 32'(MAX_WAIT);
  assign starved         = 1'b0;
`endif

endmodule
